gb_timer: RTL and testbench
===========================

# gb_timer

Game Boy DIV/TIMA/TMA/TAC timer unit. Sits directly downstream of the CPU clock divider: consumes its divided clock output as a tick source, maintains the 16-bit system counter, and exposes the four timer registers (FF04–FF07) on a small register bus. Raises a one-cycle timer interrupt request to the interrupt controller on TIMA overflow.

## Interface
- No parameters. Counter width is 16 bits; register width is 8 bits.
- clock_in  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; 0 forces all state to reset values immediately.
- clock_div_in  input  1  divided clock from the clock divider; each rising edge is one tick.
- cs  input  1  register select.
- we  input  1  write enable; qualified by cs.
- addr  input  2  00=DIV, 01=TIMA, 10=TMA, 11=TAC.
- wdata  input  8  write data.
- rdata  output  8  read data, combinational from addr.
- timer_irq  output  1  one clock_in cycle pulse on TIMA reload.

## Operation
- Tick detect: div_prev is registered from clock_div_in every cycle. tick = clock_div_in & ~div_prev.
- System counter sys_cnt[15:0] increments by 1 (wraps FFFF->0000) on every tick. DIV = sys_cnt[15:8].
- Write DIV (any wdata) clears sys_cnt to 0000. A simultaneous tick is lost; the write wins.
- TAC[2] = enable, TAC[1:0] = select: 00->sys_cnt[9], 01->sys_cnt[3], 10->sys_cnt[5], 11->sys_cnt[7].
- tsig = TAC[2] & sys_cnt[sel]. tsig_d is registered every cycle. inc = tsig_d & ~tsig, a falling edge.
- Falling edges from DIV writes or TAC writes (disable, reselect) increment TIMA, matching hardware.
- On inc with TIMA=FF: TIMA becomes 00 and ovf_pending is set.
- While ovf_pending, the next tick does TIMA<=TMA, clears ovf_pending, and pulses timer_irq for that cycle.
- Write TIMA while ovf_pending: written value kept, ovf_pending cleared, no irq, no reload.
- Write TIMA on the same cycle as inc: write wins, no increment.
- Write TMA on the reload cycle: the new wdata is what loads into TIMA.
- Read map: DIV; TIMA; TMA; {5'b11111, TAC[2:0]}. rdata does not depend on cs.
- Writes ignored when cs=0 or we=0.

## Timing
- Reset values: sys_cnt=0000, TIMA=00, TMA=00, TAC=000, div_prev=0, tsig_d=0, ovf_pending=0, timer_irq=0. rdata reflects these, so reading TAC returns F8.
- Tick latency: sys_cnt updates at the first posedge where clock_div_in=1 and div_prev=0. It updates exactly once per divided-clock high phase.
- TIMA increment latency: one clock_in cycle after the sys_cnt/TAC change that drops tsig.
- Overflow to irq: TIMA reads 00 for at least one tick. Reload and irq occur on the following tick.
- Register writes take effect at the posedge where cs&we. Read-after-write is visible next cycle.
- Reset asserted mid-operation clears all state asynchronously, including a pending overflow. No irq follows reset release.
- Reset release: first tick is possible at the first posedge with clock_div_in=1. If clock_div_in is already high at release, it counts as a rising edge.

## Test plan
- Reset then read all four addresses -> 00, 00, 00, F8. timer_irq stays 0.
- Drive 256 ticks, TAC=000 -> DIV=01, TIMA=00. Write DIV -> DIV=00 next cycle.
- TAC=101 (bit3 source), TIMA=FE, TMA=A5, apply 32 ticks -> TIMA=FF after 16 and 00 after 32. Next tick: TIMA=A5 with a single 1-cycle timer_irq.
- Overflow to 00, then write TIMA=40 before the next tick -> TIMA=40, no irq, no reload.
- TAC=101 with sys_cnt[3]=1, write DIV -> TIMA increments by exactly 1. Write TAC=001 from 101 with sys_cnt[3]=1 -> TIMA increments by 1.
- Assert reset while ovf_pending=1, then release and tick -> TIMA=00, no irq, all registers at reset values.

Source files
------------

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer: 16-bit system counter driven by divided-clock
// rising edges, TIMA clocked by falling edges of the selected counter bit.
module gb_timer (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       clock_div_in,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       timer_irq
);

  typedef enum logic [1:0] {
    REG_DIV  = 2'b00,
    REG_TIMA = 2'b01,
    REG_TMA  = 2'b10,
    REG_TAC  = 2'b11
  } reg_e;

  logic [15:0] sys_cnt;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic        div_prev;
  logic        tsig_d;
  logic        ovf_pending;

  logic        tick;
  logic        sel_bit;
  logic        tsig;
  logic        inc;
  logic        wr;
  reg_e        reg_sel;

  assign reg_sel = reg_e'(addr);
  assign wr      = cs & we;
  assign tick    = clock_div_in & ~div_prev;

  always_comb begin
    sel_bit = 1'b0;
    case (tac[1:0])
      2'b00:   sel_bit = sys_cnt[9];
      2'b01:   sel_bit = sys_cnt[3];
      2'b10:   sel_bit = sys_cnt[5];
      default: sel_bit = sys_cnt[7];
    endcase
  end

  // Disabling, reselecting or clearing the counter can all drop tsig and clock TIMA.
  assign tsig = tac[2] & sel_bit;
  assign inc  = tsig_d & ~tsig;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      sys_cnt     <= '0;
      tima        <= '0;
      tma         <= '0;
      tac         <= '0;
      div_prev    <= 1'b0;
      tsig_d      <= 1'b0;
      ovf_pending <= 1'b0;
      timer_irq   <= 1'b0;
    end else begin
      div_prev  <= clock_div_in;
      tsig_d    <= tsig;
      timer_irq <= 1'b0;

      if (wr && reg_sel == REG_DIV)
        sys_cnt <= '0;
      else if (tick)
        sys_cnt <= sys_cnt + 16'd1;

      if (wr && reg_sel == REG_TMA)
        tma <= wdata;

      if (wr && reg_sel == REG_TAC)
        tac <= wdata[2:0];

      // A TIMA write beats both reload and increment; reload picks up a same-cycle TMA write.
      if (wr && reg_sel == REG_TIMA) begin
        tima        <= wdata;
        ovf_pending <= 1'b0;
      end else if (ovf_pending && tick) begin
        tima        <= (wr && reg_sel == REG_TMA) ? wdata : tma;
        ovf_pending <= 1'b0;
        timer_irq   <= 1'b1;
      end else if (inc) begin
        if (tima == 8'hFF) begin
          tima        <= '0;
          ovf_pending <= 1'b1;
        end else begin
          tima <= tima + 8'd1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_DIV:  rdata = sys_cnt[15:8];
      REG_TIMA: rdata = tima;
      REG_TMA:  rdata = tma;
      default:  rdata = {5'b11111, tac};
    endcase
  end

endmodule

// File: tb/tb_gb_timer.sv
// Scenario bench for gb_timer: expected register values are queued when stimulus
// is applied and popped when the register is read back.
module tb_gb_timer;

  logic       clk;
  logic       rst_n;
  logic       div_clk;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       timer_irq;

  int unsigned total;
  int unsigned bad;
  int unsigned irq_cnt;
  logic [7:0]  exp_q[$];

  gb_timer dut (
    .clock_in    (clk),
    .reset       (rst_n),
    .clock_div_in(div_clk),
    .cs          (cs),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .timer_irq   (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (timer_irq === 1'b1) irq_cnt++;

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      div_clk = 1'b1;
      @(negedge clk);
      div_clk = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a;
    #1 v = rdata;
  endtask

  task automatic test_reset;
    logic [7:0] got, e;
    int unsigned base;
    base = irq_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'hF8);
    for (int unsigned a = 0; a < 4; a++) begin
      rd(2'(a), got);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL reset_reg%0d: got %02h expected %02h", a, got, e); end
    end
    total++;
    if (irq_cnt - base != 0) begin bad++; $display("FAIL reset_irq: got %0d pulses expected 0", irq_cnt - base); end
  endtask

  task automatic test_div;
    logic [7:0] got, e;
    tick(256);
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    rd(2'd0, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL div_256: got %02h expected %02h", got, e); end
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL tima_disabled: got %02h expected %02h", got, e); end
    wr(2'd0, 8'h5A);
    exp_q.push_back(8'h00);
    rd(2'd0, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL div_clear: got %02h expected %02h", got, e); end
  endtask

  task automatic test_overflow;
    logic [7:0] got, e;
    int unsigned base;
    wr(2'd3, 8'h05);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'hFE);
    wr(2'd2, 8'hA5);
    base = irq_cnt;
    tick(16);
    exp_q.push_back(8'hFF);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL ovf_16: got %02h expected %02h", got, e); end
    tick(16);
    exp_q.push_back(8'h00);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL ovf_32: got %02h expected %02h", got, e); end
    total++;
    if (irq_cnt - base != 0) begin bad++; $display("FAIL ovf_early_irq: got %0d pulses expected 0", irq_cnt - base); end
    tick(1);
    exp_q.push_back(8'hA5);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL ovf_reload: got %02h expected %02h", got, e); end
    total++;
    if (irq_cnt - base != 1) begin bad++; $display("FAIL ovf_irq: got %0d pulse cycles expected 1", irq_cnt - base); end
  endtask

  task automatic test_ovf_write;
    logic [7:0] got, e;
    int unsigned base;
    wr(2'd0, 8'h00);
    tick(8);
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h00);
    exp_q.push_back(8'h00);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL ovfw_zero: got %02h expected %02h", got, e); end
    base = irq_cnt;
    wr(2'd1, 8'h40);
    tick(1);
    exp_q.push_back(8'h40);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL ovfw_kept: got %02h expected %02h", got, e); end
    total++;
    if (irq_cnt - base != 0) begin bad++; $display("FAIL ovfw_irq: got %0d pulses expected 0", irq_cnt - base); end
  endtask

  task automatic test_falling_edges;
    logic [7:0] got, e;
    wr(2'd0, 8'h00);
    tick(8);
    wr(2'd1, 8'h10);
    exp_q.push_back(8'h10);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL edge_start: got %02h expected %02h", got, e); end
    wr(2'd0, 8'hFF);
    exp_q.push_back(8'h11);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL edge_divwr: got %02h expected %02h", got, e); end
    tick(8);
    exp_q.push_back(8'h11);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL edge_rise: got %02h expected %02h", got, e); end
    wr(2'd3, 8'h01);
    exp_q.push_back(8'h12); exp_q.push_back(8'hF9);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL edge_tacwr: got %02h expected %02h", got, e); end
    rd(2'd3, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL tac_read: got %02h expected %02h", got, e); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got, e;
    int unsigned base;
    wr(2'd3, 8'h05);
    wr(2'd0, 8'h00);
    tick(8);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h77);
    exp_q.push_back(8'h77);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL b2b_tima_vs_inc: got %02h expected %02h", got, e); end
    tick(8);
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h00);
    @(negedge clk);
    base = irq_cnt;
    div_clk = 1'b1; cs = 1'b1; we = 1'b1; addr = 2'd2; wdata = 8'h3C;
    @(negedge clk);
    div_clk = 1'b0; cs = 1'b0; we = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h3C);
    rd(2'd1, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL b2b_tma_reload: got %02h expected %02h", got, e); end
    rd(2'd2, got); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL b2b_tma: got %02h expected %02h", got, e); end
    total++;
    if (irq_cnt - base != 1) begin bad++; $display("FAIL b2b_irq: got %0d pulse cycles expected 1", irq_cnt - base); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] got, e;
    int unsigned base;
    wr(2'd0, 8'h00);
    tick(8);
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h00);
    @(negedge clk);
    base = irq_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'hF8);
    for (int unsigned a = 0; a < 4; a++) begin
      rd(2'(a), got);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL rstmid_reg%0d: got %02h expected %02h", a, got, e); end
    end
    total++;
    if (irq_cnt - base != 0) begin bad++; $display("FAIL rstmid_irq: got %0d pulses expected 0", irq_cnt - base); end
  endtask

  initial begin
    total = 0; bad = 0; irq_cnt = 0;
    rst_n = 1'b0; div_clk = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_div;
    test_overflow;
    test_ovf_write;
    test_falling_edges;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
